// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and segment-pattern decode for the
// scanned 7-segment display receiver.
package seg7_pkg;

    localparam logic [6:0] SEG_A = 7'h01;
    localparam logic [6:0] SEG_B = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_D = 7'h08;
    localparam logic [6:0] SEG_E = 7'h10;
    localparam logic [6:0] SEG_F = 7'h20;
    localparam logic [6:0] SEG_G = 7'h40;

    localparam logic [6:0] PAT_0 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
    localparam logic [6:0] PAT_1 = SEG_B | SEG_C;
    localparam logic [6:0] PAT_2 = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
    localparam logic [6:0] PAT_3 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
    localparam logic [6:0] PAT_4 = SEG_B | SEG_C | SEG_F | SEG_G;
    localparam logic [6:0] PAT_5 = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
    localparam logic [6:0] PAT_6 = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] PAT_7 = SEG_A | SEG_B | SEG_C;
    localparam logic [6:0] PAT_8 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] PAT_9 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;

    localparam logic [3:0] BLANK   = 4'hF;
    localparam logic [3:0] INVALID = 4'hE;

    typedef enum logic [1:0] {HUNT, SETTLE, WAIT_NEXT} scan_state_t;

    function automatic logic [3:0] seg7_decode(input logic [6:0] pat);
        logic [3:0] code;
        case (pat)
            PAT_0:   code = 4'd0;
            PAT_1:   code = 4'd1;
            PAT_2:   code = 4'd2;
            PAT_3:   code = 4'd3;
            PAT_4:   code = 4'd4;
            PAT_5:   code = 4'd5;
            PAT_6:   code = 4'd6;
            PAT_7:   code = 4'd7;
            PAT_8:   code = 4'd8;
            PAT_9:   code = 4'd9;
            7'h00:   code = BLANK;
            default: code = INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to 4-bit digit code, with invalid flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       invalid
);
    assign code    = seg7_decode(pattern);
    assign invalid = (code == INVALID);
endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a scanned 7-segment bus, rebuilds whole frames of digit codes and
// publishes a frame once it has repeated STABLE_FRAMES times.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_in,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic                    valid_o,
    input  logic                    ready_in,
    output logic                    err_o,
    output logic                    drop_o
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]            seg_meta, seg_sync;
    logic [NUM_DIGITS-1:0] sel_meta, sel_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_meta <= '0;
            seg_sync <= '0;
            sel_meta <= '0;
            sel_sync <= '0;
        end else begin
            seg_meta <= seg_in;
            seg_sync <= seg_meta;
            sel_meta <= dig_sel_in;
            sel_sync <= sel_meta;
        end
    end

    logic             sel_gap, sel_one, sel_ill;
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        sel_gap = (sel_sync == '0);
        sel_one = !sel_gap && ((sel_sync & (sel_sync - NUM_DIGITS'(1))) == '0);
        sel_ill = !sel_gap && !sel_one;
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (sel_sync[i]) sel_idx = IDX_W'(i);
    end

    logic [3:0] dec_code;
    logic       dec_invalid;

    seg7_pattern_decode u_dec (
        .pattern (seg_sync),
        .code    (dec_code),
        .invalid (dec_invalid)
    );

    scan_state_t                state, state_n;
    logic [IDX_W-1:0]           cur_idx;
    logic [IDX_W:0]             k_plus1;
    logic [7:0]                 settle_cnt;
    logic [6:0]                 seg_ref;
    logic                       gap_seen, frame_bad, published;
    logic [NUM_DIGITS-1:0]      captured;
    logic [NUM_DIGITS-1:0][3:0] frame, prev_frame;
    logic [3:0]                 match_cnt, match_n;
    logic go_settle, cnt_clr, cnt_inc, capture, abort, complete, new_idx, next_ok, publish;

    always_comb begin
        state_n   = state;
        go_settle = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        complete  = 1'b0;
        new_idx   = 1'b0;
        k_plus1   = {1'b0, cur_idx} + (IDX_W+1)'(1);
        next_ok   = (k_plus1 == {1'b0, sel_idx});
        case (state)
            HUNT: begin
                if (sel_one && sel_idx == '0) begin
                    state_n   = SETTLE;
                    go_settle = 1'b1;
                end
            end
            SETTLE: begin
                // gaps neither count nor restart the settle window
                if (sel_ill) abort = 1'b1;
                else if (sel_one && sel_idx != cur_idx) new_idx = 1'b1;
                else if (sel_one) begin
                    if (seg_sync != seg_ref) cnt_clr = 1'b1;
                    else if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
                        capture = 1'b1;
                        state_n = WAIT_NEXT;
                    end else cnt_inc = 1'b1;
                end
            end
            WAIT_NEXT: begin
                // same index only counts as new after an intervening gap
                if (sel_ill) abort = 1'b1;
                else if (sel_one && (sel_idx != cur_idx || gap_seen)) new_idx = 1'b1;
            end
            default: state_n = HUNT;
        endcase
        if (new_idx) begin
            if (next_ok) begin
                go_settle = 1'b1;
                state_n   = SETTLE;
            end else if (sel_idx == '0 && (&captured)) begin
                complete  = 1'b1;
                go_settle = 1'b1;
                state_n   = SETTLE;
            end else abort = 1'b1;
        end
        if (abort) state_n = HUNT;
    end

    always_comb begin
        if (frame != prev_frame) match_n = 4'd1;
        else if (match_cnt >= 4'(STABLE_FRAMES)) match_n = 4'(STABLE_FRAMES);
        else match_n = match_cnt + 4'd1;
        publish = complete && !frame_bad && (match_n == 4'(STABLE_FRAMES)) &&
                  (!published || frame != value_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            cur_idx    <= '0;
            settle_cnt <= '0;
            seg_ref    <= '0;
            gap_seen   <= 1'b0;
            captured   <= '0;
            frame      <= '0;
            frame_bad  <= 1'b0;
            prev_frame <= '0;
            match_cnt  <= '0;
            published  <= 1'b0;
            value_o    <= '0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            state <= state_n;
            if (go_settle) begin
                cur_idx    <= sel_idx;
                settle_cnt <= '0;
                seg_ref    <= seg_sync;
            end else if (cnt_clr) begin
                settle_cnt <= '0;
                seg_ref    <= seg_sync;
            end else if (cnt_inc) settle_cnt <= settle_cnt + 8'd1;

            if (capture) begin
                frame[cur_idx]    <= dec_code;
                captured[cur_idx] <= 1'b1;
                frame_bad         <= frame_bad | dec_invalid;
                gap_seen          <= 1'b0;
            end else if (state == WAIT_NEXT && sel_gap) gap_seen <= 1'b1;

            if (abort || complete) begin
                captured  <= '0;
                frame_bad <= 1'b0;
            end

            if (complete) begin
                if (frame_bad) match_cnt <= '0;
                else begin
                    match_cnt  <= match_n;
                    prev_frame <= frame;
                end
            end

            err_o  <= abort || (complete && frame_bad);
            drop_o <= publish && valid_o && !ready_in;
            if (publish) begin
                value_o   <= frame;
                valid_o   <= 1'b1;
                published <= 1'b1;
            end else if (valid_o && ready_in) valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Table-driven and randomized frame-level checks of seg7_scan_decoder.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 8;
    localparam int SF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] dig_sel_in = '0;
    logic          ready_in = 1'b0;
    logic [15:0]   value_o;
    logic          valid_o, err_o, drop_o;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC), .STABLE_FRAMES(SF)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_sel_in (dig_sel_in),
        .value_o    (value_o),
        .valid_o    (valid_o),
        .ready_in   (ready_in),
        .err_o      (err_o),
        .drop_o     (drop_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, err_seen = 0, drop_seen = 0;
    logic [6:0] pat_lut [16];

    always @(negedge clk) begin
        if (err_o) err_seen++;
        if (drop_o) drop_seen++;
    end

    typedef struct {
        logic [15:0] codes;
        logic [15:0] exp_value;
        logic        exp_valid;
        int          exp_err;
    } vec_t;
    vec_t tbl [5];

    // frame-level reference state
    logic [15:0] m_prev, m_val;
    int          m_match, m_err, m_drop;
    bit          m_valid, m_pub;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; dig_sel_in = '0; seg_in = '0; ready_in = 1'b0;
        tick(2);
        err_seen = 0; drop_seen = 0;
        rst = 1'b0;
    endtask

    task automatic scan_digit(input int k, input logic [6:0] pat, input int hold, input bit pulse_rdy);
        dig_sel_in = 4'(1 << k);
        seg_in     = pat;
        tick(hold / 2);
        if (pulse_rdy) begin
            ready_in = 1'b1; tick(1); ready_in = 1'b0;
            tick(hold - hold / 2 - 1);
        end else tick(hold - hold / 2);
        dig_sel_in = '0;
        seg_in     = '0;
        tick(2);
    endtask

    task automatic scan_frame(input logic [15:0] codes, input int hold);
        for (int k = 0; k < ND; k++) scan_digit(k, pat_lut[codes[4*k +: 4]], hold, 1'b0);
    endtask

    function automatic logic [6:0] rand_invalid();
        logic [6:0] p;
        bit ok;
        do begin
            p  = 7'($urandom_range(1, 127));
            ok = 1'b1;
            for (int c = 0; c < 10; c++) if (p == pat_lut[c]) ok = 1'b0;
        end while (!ok);
        return p;
    endfunction

    task automatic gen_frame(output logic [15:0] codes, output logic [3:0][6:0] pats);
        for (int k = 0; k < ND; k++) begin
            int x;
            x = $urandom_range(0, 19);
            if (x < 15) begin
                codes[4*k +: 4] = 4'(x % 10);
                pats[k] = pat_lut[x % 10];
            end else if (x < 18) begin
                codes[4*k +: 4] = 4'hF;
                pats[k] = 7'h00;
            end else begin
                codes[4*k +: 4] = 4'hE;
                pats[k] = rand_invalid();
            end
        end
    endtask

    task automatic model_complete(input logic [15:0] codes);
        bit bad = 1'b0;
        for (int k = 0; k < ND; k++) if (codes[4*k +: 4] == 4'hE) bad = 1'b1;
        if (bad) begin
            m_err++;
            m_match = 0;
        end else begin
            if (codes == m_prev) m_match = (m_match < SF) ? m_match + 1 : SF;
            else begin
                m_match = 1;
                m_prev  = codes;
            end
            if (m_match == SF && (codes != m_val || !m_pub)) begin
                if (m_valid) m_drop++;
                m_val = codes; m_valid = 1'b1; m_pub = 1'b1;
            end
        end
    endtask

    initial begin
        logic [15:0]     cur_codes, last_codes;
        logic [3:0][6:0] cur_pats;
        int              nfr;

        pat_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h49, 7'h00};
        tbl[0] = '{16'h4321, 16'h4321, 1'b1, 0};
        tbl[1] = '{16'h0000, 16'h0000, 1'b1, 0};
        tbl[2] = '{16'hF987, 16'hF987, 1'b1, 0};
        tbl[3] = '{16'h5F60, 16'h5F60, 1'b1, 0};
        tbl[4] = '{16'h4E21, 16'h0000, 1'b0, 2};

        do_reset();
        check("reset_outputs", {13'd0, value_o, valid_o, err_o, drop_o}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            scan_frame(tbl[i].codes, 20);
            scan_frame(tbl[i].codes, 20);
            scan_digit(0, pat_lut[tbl[i].codes[3:0]], 20, 1'b0);
            check("tbl_value", {16'd0, value_o}, {16'd0, tbl[i].exp_value});
            check("tbl_valid", {31'd0, valid_o}, {31'd0, tbl[i].exp_valid});
            check("tbl_err", err_seen, tbl[i].exp_err);
            check("tbl_drop", drop_seen, 0);
            tick(5);
            check("tbl_valid_hold", {31'd0, valid_o}, {31'd0, tbl[i].exp_valid});
            ready_in = 1'b1; tick(1); ready_in = 1'b0;
            check("tbl_valid_after_ready", {31'd0, valid_o}, 32'd0);
        end

        // holds shorter than the settle window never capture
        do_reset();
        repeat (3) scan_frame(16'h4321, 5);
        check("short_valid", {31'd0, valid_o}, 32'd0);
        check("short_err", err_seen, 2);
        scan_frame(16'h4321, 20);
        scan_frame(16'h4321, 20);
        scan_digit(0, pat_lut[1], 20, 1'b0);
        check("short_then_long_value", {16'd0, value_o}, 32'h4321);
        check("short_then_long_valid", {31'd0, valid_o}, 32'd1);
        check("short_then_long_err", err_seen, 3);

        // skipped digit aborts the frame
        do_reset();
        scan_digit(0, pat_lut[1], 20, 1'b0);
        scan_digit(1, pat_lut[2], 20, 1'b0);
        scan_digit(3, pat_lut[4], 20, 1'b0);
        check("skip_err", err_seen, 1);
        check("skip_valid", {31'd0, valid_o}, 32'd0);
        scan_frame(16'h4321, 20);
        scan_frame(16'h4321, 20);
        scan_digit(0, pat_lut[1], 20, 1'b0);
        check("skip_recover_value", {16'd0, value_o}, 32'h4321);
        check("skip_recover_err", err_seen, 1);

        // second stable value overwrites an unaccepted first one
        do_reset();
        scan_frame(16'h2580, 20);
        scan_frame(16'h2580, 20);
        scan_frame(16'h7913, 20);
        scan_frame(16'h7913, 20);
        scan_digit(0, pat_lut[3], 20, 1'b0);
        check("drop_count", drop_seen, 1);
        check("drop_value", {16'd0, value_o}, 32'h7913);
        check("drop_valid", {31'd0, valid_o}, 32'd1);

        // reset in the middle of digit 2
        scan_digit(1, pat_lut[1], 20, 1'b0);
        dig_sel_in = 4'b0100; seg_in = pat_lut[3];
        tick(10);
        rst = 1'b1; tick(1);
        check("midreset_outputs", {13'd0, value_o, valid_o, err_o, drop_o}, 32'd0);
        rst = 1'b0; err_seen = 0; drop_seen = 0;
        tick(10);
        dig_sel_in = '0; seg_in = '0;
        tick(2);
        scan_frame(16'h0909, 20);
        scan_frame(16'h0909, 20);
        scan_digit(0, pat_lut[9], 20, 1'b0);
        check("midreset_value", {16'd0, value_o}, 32'h0909);
        check("midreset_valid", {31'd0, valid_o}, 32'd1);
        check("midreset_err", err_seen, 0);

        // randomized frame streams against the frame-level model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            m_prev = '0; m_val = '0; m_match = 0; m_err = 0; m_drop = 0;
            m_valid = 1'b0; m_pub = 1'b0;
            last_codes = '0; cur_codes = '0; cur_pats = '0;
            nfr = $urandom_range(3, 6);
            for (int f = 0; f <= nfr; f++) begin
                bit rdy;
                rdy = ($urandom_range(0, 3) == 0);
                if (f == 0 || $urandom_range(0, 2) == 0) gen_frame(cur_codes, cur_pats);
                scan_digit(0, cur_pats[0], 20, 1'b0);
                if (f > 0) model_complete(last_codes);
                if (f < nfr) begin
                    for (int k = 1; k < ND; k++)
                        scan_digit(k, cur_pats[k], 20, (k == 2) && rdy);
                    if (rdy) m_valid = 1'b0;
                    last_codes = cur_codes;
                end
            end
            check("rand_value", {16'd0, value_o}, {16'd0, m_val});
            check("rand_valid", {31'd0, valid_o}, {31'd0, m_valid});
            check("rand_err", err_seen, m_err);
            check("rand_drop", drop_seen, m_drop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment display path: snoops a multiplexed (scanned) 7-segment display bus, i.e. segment lines plus one-hot digit-select lines.
- Recovers each digit's segment pattern, decodes it back to a 4-bit code, assembles a full multi-digit frame, and publishes it only after it is stable across several scans.
- Sits between the display-board pins and the turbine telemetry logic. It lets the design read values driven onto existing displays.

Parameters:
- NUM_DIGITS, 4: number of scanned digits, 1..8.
- SETTLE_CYCLES, 8: consecutive stable cycles of a select before segments are captured, 1..255.
- STABLE_FRAMES, 2: consecutive identical complete frames required before publishing, 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines, active-high; bit0=a, bit1=b … bit6=g.
- dig_sel_in  in  NUM_DIGITS  digit select, active-high one-hot; bit0 = first digit scanned.
- value_o  out  4*NUM_DIGITS  published frame; digit i in bits [4i+3:4i].
- valid_o  out  1  value_o holds an unaccepted frame.
- ready_in  in  1  consumer accepts value_o when valid_o&ready_in.
- err_o  out  1  one-cycle pulse per aborted frame.
- drop_o  out  1  one-cycle pulse when an unaccepted frame is overwritten.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Input synchronisation:
  - seg_in and dig_sel_in each pass through a 2-flop synchroniser; all logic below uses the synchronised copies.
  - Input-to-decision latency is 2 cycles plus settling.
- Select classification:
  - all-zero = gap, which is ignored and is not a change.
  - exactly one bit set = digit index k.
  - more than one bit set = illegal.
- Decode table, g..a as hex:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 00 = blank, code F.
  - Any other pattern = invalid, code E. An invalid pattern marks the frame bad.
- FSM states: HUNT, SETTLE, WAIT_NEXT.
  - HUNT: wait for select index 0, then go to SETTLE with settle counter=0. Any other select stays in HUNT.
  - SETTLE: counter increments while select and segments are both unchanged; any change of either restarts the counter at 0.
    - A change of select to another legal index is handled as in WAIT_NEXT.
    - When the count reaches SETTLE_CYCLES, store the decoded code into frame slot k, set captured[k], and go to WAIT_NEXT.
  - WAIT_NEXT: on a new legal index j:
    - If j==k+1, go to SETTLE.
    - If j==0 and all captured bits are set, complete the frame, then go to SETTLE for index 0 of the next frame.
    - Otherwise (skip, repeat, illegal select, j==0 with a missing slot), abort: pulse err_o, clear captured, go to HUNT.
  - An illegal select in any state except HUNT also aborts.
- Frame completion:
  - A bad frame pulses err_o and resets match_cnt=0.
  - Otherwise, if the frame equals the previous completed frame, match_cnt increments, saturating at STABLE_FRAMES; else match_cnt=1 and the previous frame is updated.
  - Publish when match_cnt reaches STABLE_FRAMES and the frame ≠ value_o (or nothing has been published since reset). match_cnt stays saturated; identical frames do not republish.
- Publish:
  - value_o<=frame and valid_o<=1 in the cycle after frame completion.
  - If valid_o was already 1 and ready_in is 0 in that cycle, pulse drop_o; the newest frame wins.
  - valid_o clears the cycle after valid_o&ready_in unless a publish occurs in that same cycle, in which case valid_o stays 1 with the new value and no drop.
- NUM_DIGITS=1: every index-0 select after capture completes a frame.
- Reset values: value_o=0, valid_o=0, err_o=0, drop_o=0. FSM in HUNT; counters, captured bits and the previous frame are cleared. A reset mid-frame discards partial data; no err_o pulse.

Decomposition:
- Package seg7_pkg holds:
  - segment bit constants SEG_A..SEG_G;
  - the ten digit-pattern constants;
  - codes BLANK=4'hF and INVALID=4'hE;
  - the FSM state enum;
  - a pure decode function.
- One sub-module, seg7_pattern_decode (7-bit pattern to 4-bit code plus invalid flag, combinational), is instantiated once on the synchronised segments.

Test Plan (NUM_DIGITS=4, SETTLE_CYCLES=8, STABLE_FRAMES=2):
- Scan "1234" (06,5B,4F,66), 20 cycles per digit with a 2-cycle gap, 2 frames → after the second frame completes, value_o=16'h4321 (digit0=1 in the low nibble), valid_o=1 held until ready_in; err_o never pulses.
- Select held only 5 cycles per digit → no capture, no valid_o; then 20-cycle holds → normal publish.
- Segment pattern 0x49 on digit 2 → err_o pulse at the frame boundary, match_cnt reset, no publish.
- Select order 0,1,3 → err_o pulse on the select to 3, FSM returns to HUNT, next clean 2 frames publish.
- Two stable distinct values published with ready_in=0 → drop_o pulses once, value_o shows the second value.
- rst asserted mid-digit-2 → all outputs 0 the next cycle; two subsequent clean frames publish correctly.
